ram8: RTL and testbench

- Eight-word, WIDTH-bit random-access memory. It is the first storage stage built on top of the elementary gate layer.
- Consumes the NOT/AND/OR/MUX/DMUX gates for write-enable decode and read select. Adds clocked state through per-bit D flip-flops.
- Feeds the larger RAM64/register-file stages and the CPU data path.

---
 rtl/ram8_pkg.sv | 16 +
 rtl/ram8_word_register.sv | 48 ++++
 rtl/ram8.sv | 69 ++++++
 tb/tb_ram8.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram8_pkg
// Description : Shared sizing constants for the RAM8 storage stage and the
//               larger memory / datapath stages built on top of it.
//               Contents: WORD_WIDTH, RAM8_ADDR_W, RAM8_DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
package ram8_pkg;

  localparam int WORD_WIDTH  = 16;  // default data word width
  localparam int RAM8_ADDR_W = 3;   // word-select width of an 8-word bank
  localparam int RAM8_DEPTH  = 8;   // words per bank

endpackage : ram8_pkg
`default_nettype wire

// File: rtl/ram8_word_register.sv
`default_nettype none
// ============================================================================
// Module      : word_register
// Description : WIDTH-bit register made of single-bit cells. Each cell is a
//               D flip-flop fed by a 2:1 mux that selects between holding its
//               value and taking the new data bit. Reset forces D to 0.
// Ports       : clk_i  - clock, rising edge
//               rst_i  - synchronous active-high clear
//               load_i - write enable
//               d_i    - write data  [WIDTH-1:0]
//               q_o    - stored word [WIDTH-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module word_register
  import ram8_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] bit_q;
  logic [WIDTH-1:0] bit_d;

  generate
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      // Reset wins over load: the cleared value is forced at the D input.
      always_comb begin
        bit_d[b] = load_i ? d_i[b] : bit_q[b];
        if (rst_i) begin
          bit_d[b] = 1'b0;
        end
      end

      always_ff @(posedge clk_i) begin
        bit_q[b] <= bit_d[b];
      end
    end
  endgenerate

  assign q_o = bit_q;

endmodule : word_register
`default_nettype wire

// File: rtl/ram8.sv
`default_nettype none
// ============================================================================
// Module      : ram8
// Description : Eight-word, WIDTH-bit random-access memory. A 1-to-8 DMUX
//               tree steers LOAD to exactly one word register; an 8-to-1 MUX
//               tree returns the addressed word combinationally. Writes take
//               effect at the rising edge, so a read in the write cycle shows
//               the old word.
// Ports       : CLK     - clock, rising edge
//               RST     - synchronous active-high clear of all words
//               IN      - write data [WIDTH-1:0]
//               LOAD    - write enable for word[ADDRESS]
//               ADDRESS - word select for write and read [2:0]
//               OUT     - word[ADDRESS] [WIDTH-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module ram8
  import ram8_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = RAM8_DEPTH   // fixed at 8; ADDRESS is 3 bits
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [WIDTH-1:0]       IN,
  input  logic                   LOAD,
  input  logic [RAM8_ADDR_W-1:0] ADDRESS,
  output logic [WIDTH-1:0]       OUT
);

  // Both trees use heap numbering: node 1 is the root, node n has children
  // 2n (select bit 0) and 2n+1 (select bit 1), leaves DEPTH..2*DEPTH-1 map to
  // words 0..DEPTH-1. The root level is steered by the address MSB, so leaf
  // index is DEPTH + ADDRESS.
  logic             w_dmux [1:2*DEPTH-1];
  logic [WIDTH-1:0] w_mux  [1:2*DEPTH-1];

  assign w_dmux[1] = LOAD;

  generate
    for (genvar n = 1; n < DEPTH; n++) begin : g_node
      localparam int LVL = $clog2(n + 1) - 1;       // depth of node n
      localparam int SEL = RAM8_ADDR_W - 1 - LVL;   // address bit for LVL

      // DMUX: pass the parent enable to the child chosen by the select bit.
      assign w_dmux[2*n]   = w_dmux[n] & ~ADDRESS[SEL];
      assign w_dmux[2*n+1] = w_dmux[n] &  ADDRESS[SEL];

      // MUX: pick the child chosen by the same select bit.
      assign w_mux[n] = ADDRESS[SEL] ? w_mux[2*n+1] : w_mux[2*n];
    end

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
      word_register #(
        .WIDTH (WIDTH)
      ) u_word (
        .clk_i  (CLK),
        .rst_i  (RST),
        .load_i (w_dmux[DEPTH + w]),
        .d_i    (IN),
        .q_o    (w_mux[DEPTH + w])
      );
    end
  endgenerate

  assign OUT = w_mux[1];

endmodule : ram8
`default_nettype wire

// File: tb/tb_ram8.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram8
// Description : Self-checking bench for ram8 against an array memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram8;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] IN = '0;
  logic         LOAD = 1'b0;
  logic [2:0]   ADDRESS = '0;
  logic [W-1:0] OUT;

  int checks = 0;
  int errors = 0;

  // Reference memory: eight words, written by plain array indexing.
  logic [W-1:0] mem [8];

  ram8 #(.WIDTH(W), .DEPTH(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .IN      (IN),
    .LOAD    (LOAD),
    .ADDRESS (ADDRESS),
    .OUT     (OUT)
  );

  always #5 CLK = ~CLK;

  // Waits for the rising edge and applies its effect to the model using the
  // inputs present at that edge, then moves 1 ns past the edge.
  task automatic edge_update();
    logic         r, l;
    logic [2:0]   a;
    logic [W-1:0] d;
    @(posedge CLK);
    r = RST; l = LOAD; a = ADDRESS; d = IN;
    if (r) begin
      for (int i = 0; i < 8; i++) mem[i] = '0;
    end else if (l) begin
      mem[a] = d;
    end
    #1;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [W-1:0] d);
    @(negedge CLK);
    ADDRESS = a; IN = d; LOAD = 1'b1;
    edge_update();
    LOAD = 1'b0;
  endtask

  // Read sweep with LOAD low; every address compared to the model.
  task automatic sweep(input string name);
    for (int a = 0; a < 8; a++) begin
      ADDRESS = 3'(a);
      #1;
      checks++;
      if (OUT !== mem[a]) begin
        errors++;
        $display("FAIL %s addr=%0d got=%h exp=%h", name, a, OUT, mem[a]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1; LOAD = 1'b0;
    edge_update();
    RST = 1'b0;
    for (int a = 0; a < 8; a++) begin
      ADDRESS = 3'(a);
      #1;
      checks++;
      if (OUT !== 16'h0000) begin
        errors++;
        $display("FAIL reset_sweep addr=%0d got=%h exp=0000", a, OUT);
      end
    end
  endtask

  task automatic test_write_readback();
    for (int a = 0; a < 8; a++) write_word(3'(a), 16'(16'h1111 * (a + 1)));
    for (int a = 0; a < 8; a++) begin
      logic [W-1:0] exp;
      exp = 16'(16'h1111 * (a + 1));
      ADDRESS = 3'(a);
      #1;
      checks++;
      if (OUT !== exp) begin
        errors++;
        $display("FAIL write_readback addr=%0d got=%h exp=%h", a, OUT, exp);
      end
    end
  endtask

  task automatic test_read_during_write();
    write_word(3'd3, 16'hABCD);
    @(negedge CLK);
    ADDRESS = 3'd3; IN = 16'h1234; LOAD = 1'b1;
    #1;
    checks++;
    if (OUT !== 16'hABCD) begin
      errors++;
      $display("FAIL rdw_before got=%h exp=abcd", OUT);
    end
    edge_update();
    LOAD = 1'b0;
    checks++;
    if (OUT !== 16'h1234) begin
      errors++;
      $display("FAIL rdw_after got=%h exp=1234", OUT);
    end
  endtask

  task automatic test_reset_priority();
    write_word(3'd5, 16'hFFFF);
    @(negedge CLK);
    RST = 1'b1; LOAD = 1'b1; ADDRESS = 3'd5; IN = 16'h5A5A;
    edge_update();
    RST = 1'b0; LOAD = 1'b0;
    for (int a = 0; a < 8; a++) begin
      ADDRESS = 3'(a);
      #1;
      checks++;
      if (OUT !== 16'h0000) begin
        errors++;
        $display("FAIL reset_priority addr=%0d got=%h exp=0000", a, OUT);
      end
    end
  endtask

  task automatic test_hold();
    for (int a = 0; a < 8; a++) write_word(3'(a), 16'($urandom));
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      IN = 16'($urandom); ADDRESS = 3'($urandom_range(0, 7)); LOAD = 1'b0;
      edge_update();
    end
    sweep("hold");
  endtask

  // RST pulsed and released between edges must not clear anything.
  task automatic test_mid_cycle_reset();
    write_word(3'd2, 16'hC3C3);
    RST = 1'b1;
    #2;
    RST = 1'b0;
    edge_update();
    sweep("midcycle_rst");
  endtask

  task automatic test_boundary();
    write_word(3'd7, 16'hFFFF);
    write_word(3'd0, 16'h0001);
    sweep("boundary_a");
    write_word(3'd7, 16'hFFFF);
    write_word(3'd7, 16'h0000);   // back-to-back same address: last wins
    ADDRESS = 3'd7; #1;
    checks++;
    if (OUT !== 16'h0000) begin
      errors++;
      $display("FAIL boundary_a7 got=%h exp=0000", OUT);
    end
    ADDRESS = 3'd0; #1;
    checks++;
    if (OUT !== 16'h0001) begin
      errors++;
      $display("FAIL boundary_a0 got=%h exp=0001", OUT);
    end
  endtask

  // Address moved between negedge and the write edge: the edge value counts.
  task automatic test_addr_change();
    @(negedge CLK);
    ADDRESS = 3'd2; IN = 16'h7E57; LOAD = 1'b1;
    #2;
    ADDRESS = 3'd6;
    edge_update();
    LOAD = 1'b0;
    sweep("addr_change");
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK);
      RST     = ($urandom_range(0, 39) == 0);
      LOAD    = $urandom_range(0, 1) == 1;
      ADDRESS = 3'($urandom_range(0, 7));
      IN      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      #1;
      checks++;
      if (OUT !== mem[ADDRESS]) begin
        errors++;
        $display("FAIL random c=%0d addr=%0d got=%h exp=%h", c, ADDRESS, OUT, mem[ADDRESS]);
      end
      edge_update();
    end
    RST = 1'b0; LOAD = 1'b0;
    sweep("random_final");
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_read_during_write();
    test_reset_priority();
    test_hold();
    test_mid_cycle_reset();
    test_boundary();
    test_addr_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ram8
`default_nettype wire
